// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time and returns a
// 32-bit instruction with misalign/bus-error flags after fixed wait states.
module imem_responder #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DEPTH_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           WAIT_CYCLES = 1,
   parameter logic [31:0]           NOP_INSTR   = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_instr_o,
   output logic                  rsp_misalign_o,
   output logic                  rsp_bus_err_o,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [31:0]           wr_data_i
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_WIDTH:0] SPAN =
      (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t state_q, state_d;

   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q;
   logic             mis_q, bus_q;
   logic             enter_resp;

   logic             ready_q;
   logic             valid_q;
   logic [31:0]      instr_q;
   logic             mis_out_q, bus_out_q;

   logic [31:0]      mem_q [DEPTH_WORDS];

   logic [ADDR_WIDTH-1:0] req_off;
   logic                  req_mis;
   logic                  req_bus;
   logic [IDX_W-1:0]      req_idx;

   logic [ADDR_WIDTH-1:0] wr_off;
   logic                  wr_hit;
   logic [IDX_W-1:0]      wr_idx;

   logic        accept;
   logic        rsp_done;
   logic        fwd;
   logic [31:0] rd_data;

   // Offsets wrap at ADDR_WIDTH, so addresses below BASE_ADDR read as huge
   assign req_off = req_addr_i - BASE_ADDR;
   assign req_mis = |req_addr_i[1:0];
   assign req_bus = !req_mis && ({1'b0, req_off} >= SPAN);
   assign req_idx = req_off[IDX_W+1:2];

   assign wr_off = wr_addr_i - BASE_ADDR;
   assign wr_hit = wr_en_i && ({1'b0, wr_off} < SPAN);
   assign wr_idx = wr_off[IDX_W+1:2];

   assign accept   = req_valid_i && ready_q;
   assign rsp_done = valid_q && rsp_ready_i;

   assign fwd     = wr_hit && (wr_idx == idx_q);
   assign rd_data = fwd ? wr_data_i : mem_q[idx_q];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      unique case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_WAIT;
               cnt_d   = (req_mis || req_bus) ? 4'd0 : WAIT_LD;
            end
         end
         // One lookup cycle plus the programmed wait states
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_done) state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_INIT;
         cnt_q     <= '0;
         idx_q     <= '0;
         mis_q     <= 1'b0;
         bus_q     <= 1'b0;
         ready_q   <= 1'b0;
         valid_q   <= 1'b0;
         instr_q   <= '0;
         mis_out_q <= 1'b0;
         bus_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == ST_IDLE);
         if (accept) begin
            idx_q <= req_idx;
            mis_q <= req_mis;
            bus_q <= req_bus;
         end
         if (enter_resp) begin
            valid_q   <= 1'b1;
            mis_out_q <= mis_q;
            bus_out_q <= bus_q;
            instr_q   <= (mis_q || bus_q) ? NOP_INSTR : rd_data;
         end else if (rsp_done) begin
            valid_q <= 1'b0;
         end
      end
   end

   // Store contents survive reset
   always_ff @(posedge clk) begin
      if (wr_hit) mem_q[wr_idx] <= wr_data_i;
   end

   assign req_ready_o    = ready_q;
   assign rsp_valid_o    = valid_q;
   assign rsp_instr_o    = instr_q;
   assign rsp_misalign_o = mis_out_q;
   assign rsp_bus_err_o  = bus_out_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder.
// Expected responses are queued at accept and checked by a monitor.
module tb_imem_responder;

   localparam int          W     = 1;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] SPAN  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_instr_o;
   logic        rsp_misalign_o;
   logic        rsp_bus_err_o;
   logic        wr_en_i;
   logic [31:0] wr_addr_i;
   logic [31:0] wr_data_i;

   imem_responder #(
      .ADDR_WIDTH (32),
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE),
      .WAIT_CYCLES(W),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_addr_i    (req_addr_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_instr_o   (rsp_instr_o),
      .rsp_misalign_o(rsp_misalign_o),
      .rsp_bus_err_o (rsp_bus_err_o),
      .wr_en_i       (wr_en_i),
      .wr_addr_i     (wr_addr_i),
      .wr_data_i     (wr_data_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        mis;
      logic        bus;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl [DEPTH];
   int          vectors = 0;
   int          miscompares = 0;
   int          ncyc = 0;
   int          rdy_mode = 2;
   bit          started = 0;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      rsp_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rsp_ready_i = 1'($urandom_range(0, 1));
            1:       rsp_ready_i = 1'b0;
            default: rsp_ready_i = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         started = 0;
      end else if (rsp_valid_o) begin
         if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_rsp: got valid 1 want 0");
         end else begin
            if (!started) begin
               chk("latency", 32'(ncyc), 32'(q[0].due));
               started = 1;
            end
            chk("instr", rsp_instr_o, q[0].instr);
            chk("misalign", 32'(rsp_misalign_o), 32'(q[0].mis));
            chk("bus_err", 32'(rsp_bus_err_o), 32'(q[0].bus));
            chk("ready_in_resp", 32'(req_ready_o), 32'd0);
            if (rsp_ready_i) begin
               void'(q.pop_front());
               started = 0;
            end
         end
      end else if (q.size() > 0 && ncyc > q[0].due + 8) begin
         vectors++;
         miscompares++;
         $display("FAIL rsp_timeout: got none want %h", q[0].instr);
         void'(q.pop_front());
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] off;
      off       = a - BASE;
      wr_addr_i = a;
      wr_data_i = d;
      wr_en_i   = 1'b1;
      if (off < SPAN) mdl[off[11:2]] = d;
      @(posedge clk);
      #1 wr_en_i = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, input bit push,
                        input bit fwd, input logic [31:0] fd);
      exp_t        e;
      logic [31:0] off;
      bit          mis, bus, ok;
      int          k;
      mis = (a[1:0] != 2'b00);
      off = a - BASE;
      bus = !mis && (off >= SPAN);
      req_valid_i = 1'b1;
      req_addr_i  = a;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready_o) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: got ready 0 want 1");
         req_valid_i = 1'b0;
         return;
      end
      k = ncyc;
      fwd = fwd && !mis && !bus;
      if (fwd) mdl[off[11:2]] = fd;
      e.mis   = mis;
      e.bus   = bus;
      e.instr = (mis || bus) ? NOP : mdl[off[11:2]];
      e.due   = k + 2 + ((mis || bus) ? 0 : W);
      if (push) q.push_back(e);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      req_addr_i  = $urandom;
      if (fwd) begin
         repeat (W) @(posedge clk);
         #1 wr(a, fd);
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         if (q.size() == 0 && !rsp_valid_o) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d pending want 0", q.size());
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a, d;
      int          r;
      rst         = 1'b0;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      wr_en_i     = 1'b0;
      wr_addr_i   = '0;
      wr_data_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_instr", rsp_instr_o, 32'd0);
      chk("rst_flags", 32'({rsp_misalign_o, rsp_bus_err_o}), 32'd0);

      @(negedge clk);
      rst = 1'b1;
      #1 chk("ready_cycle1", 32'(req_ready_o), 32'd0);
      @(negedge clk);
      chk("ready_cycle2", 32'(req_ready_o), 32'd1);
      chk("valid_idle", 32'(rsp_valid_o), 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < DEPTH; i++) wr(BASE + 32'(4 * i), $urandom);
      wr(32'h0000_1000, 32'hBAD0_0000);
      wr(32'h0000_1004, 32'hBAD0_0004);
      wr(32'hFFFF_FFFC, 32'hBAD0_FFFC);

      wr(32'h0, 32'h0050_0093);
      fetch(32'h0, 1, 0, 0);
      fetch(32'h4, 1, 0, 0);
      fetch(32'hFFC, 1, 0, 0);
      drain();

      fetch(32'h2, 1, 0, 0);
      fetch(32'h1000, 1, 0, 0);
      fetch(32'hFFF, 1, 0, 0);
      fetch(32'hFFFF_FFFC, 1, 0, 0);
      drain();

      rdy_mode = 1;
      fetch(32'h8, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid_o) break;
      end
      repeat (5) @(negedge clk);
      rdy_mode = 2;
      drain();

      fetch(32'h4, 1, 1, 32'hDEAD_BEEF);
      fetch(32'h4, 1, 0, 0);
      drain();

      fetch(32'h1000, 1, 0, 0);
      drain();
      fetch(32'h8, 0, 0, 0);
      rst = 1'b0;
      #1;
      chk("midrst_ready", 32'(req_ready_o), 32'd0);
      chk("midrst_valid", 32'(rsp_valid_o), 32'd0);
      chk("midrst_instr", rsp_instr_o, 32'd0);
      chk("midrst_flags", 32'({rsp_misalign_o, rsp_bus_err_o}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_rsp_after_rst", 32'(rsp_valid_o), 32'd0);
      end
      @(posedge clk);
      #1;
      fetch(32'h8, 1, 0, 0);
      fetch(32'h0, 1, 0, 0);
      drain();

      rdy_mode = 0;
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 11);
         d = $urandom;
         case (r)
            6: begin
               a = $urandom;
               if (a[1:0] == 2'b00) a[0] = 1'b1;
            end
            7: begin
               a = $urandom;
               a[1:0] = 2'b00;
               a[31]  = 1'b1;
            end
            8: begin
               case ($urandom_range(0, 3))
                  0:       a = 32'h0000_0000;
                  1:       a = 32'h0000_0FFC;
                  2:       a = 32'h0000_1000;
                  default: a = 32'h0000_1004;
               endcase
            end
            default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         endcase
         if (r == 10) begin
            drain();
            a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4095));
            wr(a, d);
         end else begin
            fetch(a, 1, r == 9, d);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
      end
      rdy_mode = 2;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
